gait_sequencer: RTL and testbench

GAIT_SEQUENCER -- requirements
Module: gait_sequencer

---
 rtl/gait_pkg.sv | 65 ++++++
 rtl/gait_pose_rom.sv | 23 ++
 rtl/gait_sequencer.sv | 149 ++++++++++++++
 tb/tb_gait_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gait_pkg.sv
// gait_pkg -- shared definitions for the hexapod gait sequencer.
//   mode encoding, FSM state enum, neutral angle, per-mode pose counts,
//   and the pose tables. A pose is 48 bits: l1 at [7:0], l2 [15:8],
//   l3 [23:16], r1 [31:24], r2 [39:32], r3 [47:40], so each literal
//   below is written {r3, r2, r1, l3, l2, l1}.
package gait_pkg;

  typedef enum logic [1:0] {
    MODE_STAND = 2'd0,
    MODE_FWD   = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_LEFT  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DWELL = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  localparam logic [7:0]  NEUTRAL      = 8'd90;
  localparam logic [47:0] NEUTRAL_POSE = {6{NEUTRAL}};

  localparam logic [2:0] CNT_STAND = 3'd1;
  localparam logic [2:0] CNT_FWD   = 3'd6;
  localparam logic [2:0] CNT_RIGHT = 3'd3;
  localparam logic [2:0] CNT_LEFT  = 3'd3;

  localparam logic [47:0] FWD_TBL [0:5] = '{
    {8'd90,  8'd90, 8'd60,  8'd90,  8'd90,  8'd60 },
    {8'd110, 8'd90, 8'd70,  8'd110, 8'd110, 8'd70 },
    {8'd110, 8'd90, 8'd90,  8'd110, 8'd110, 8'd90 },
    {8'd70,  8'd70, 8'd110, 8'd70,  8'd90,  8'd110},
    {8'd70,  8'd70, 8'd90,  8'd70,  8'd90,  8'd90 },
    NEUTRAL_POSE
  };

  localparam logic [47:0] RIGHT_TBL [0:2] = '{
    {8'd60,  8'd60,  8'd100, 8'd60,  8'd60,  8'd90},
    {8'd120, 8'd120, 8'd80,  8'd120, 8'd120, 8'd80},
    NEUTRAL_POSE
  };

  localparam logic [47:0] LEFT_TBL [0:2] = '{
    {8'd120, 8'd120, 8'd90,  8'd120, 8'd120, 8'd80 },
    {8'd60,  8'd60,  8'd100, 8'd60,  8'd60,  8'd100},
    NEUTRAL_POSE
  };

  // Index of the final pose of a gait cycle for the given mode.
  function automatic logic [2:0] last_step(input mode_e m);
    logic [2:0] cnt;
    unique case (m)
      MODE_STAND: cnt = CNT_STAND;
      MODE_FWD:   cnt = CNT_FWD;
      MODE_RIGHT: cnt = CNT_RIGHT;
      MODE_LEFT:  cnt = CNT_LEFT;
    endcase
    return cnt - 3'd1;
  endfunction

endpackage

// File: rtl/gait_pose_rom.sv
// gait_pose_rom -- combinational pose lookup.
//   mode : gait mode (gait_pkg::mode_e encoding)
//   step : pose index within the cycle
//   pose : 48-bit packed joint angles; neutral for an out-of-range step
module gait_pose_rom
  import gait_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [2:0]  step,
  output logic [47:0] pose
);

  always_comb begin
    pose = NEUTRAL_POSE;
    unique case (mode_e'(mode))
      MODE_STAND: pose = NEUTRAL_POSE;
      MODE_FWD:   if (step < CNT_FWD)   pose = FWD_TBL[step];
      MODE_RIGHT: if (step < CNT_RIGHT) pose = RIGHT_TBL[step[1:0]];
      MODE_LEFT:  if (step < CNT_LEFT)  pose = LEFT_TBL[step[1:0]];
    endcase
  end

endmodule

// File: rtl/gait_sequencer.sv
// gait_sequencer -- steps the six leg joints through the pose table of the
// selected gait, waiting for every joint to settle and dwelling before
// moving on to the next pose.
//   iClk       : system clock (50 MHz)
//   iRst       : synchronous active-high reset
//   iEnable    : 1 = keep running gait cycles, 0 = stop after current cycle
//   iMode      : 0 stand, 1 forward, 2 right, 3 left (sampled per cycle)
//   iDone      : per-joint settled flags {r3,r2,r1,l3,l2,l1}
//   oAngles    : clamped target angles, l1 at [7:0] .. r3 at [47:40]
//   oStep      : current pose index
//   oBusy      : high whenever not IDLE
//   oCycleDone : one-cycle pulse in the last dwell cycle of a gait cycle
//   oFault     : sticky settle timeout, cleared only by reset
module gait_sequencer
  import gait_pkg::*;
#(
  parameter int unsigned DWELL_CYC   = 2500000,
  parameter int unsigned TIMEOUT_CYC = 50000000,
  parameter int unsigned GUARD_CYC   = 2,
  parameter logic [7:0]  ANGLE_MIN   = 8'd30,
  parameter logic [7:0]  ANGLE_MAX   = 8'd150
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEnable,
  input  logic [1:0]  iMode,
  input  logic [5:0]  iDone,
  output logic [47:0] oAngles,
  output logic [2:0]  oStep,
  output logic        oBusy,
  output logic        oCycleDone,
  output logic        oFault
);

  localparam logic [32:0] GUARD_LIM = 33'(GUARD_CYC);
  localparam logic [32:0] TMO_LIM   = 33'(TIMEOUT_CYC);
  localparam logic [32:0] DWELL_LIM = 33'(DWELL_CYC);

  state_e      state_r, state_nxt;
  logic [1:0]  mode_r;
  logic [2:0]  step_r;
  logic [2:0]  last_r;
  logic [31:0] cnt_r;
  logic [32:0] cnt_inc;
  logic        guard_end, wait_tmo, dwell_end, settled, at_last;
  logic [47:0] pose_p0;
  logic [47:0] angles_p1;

  function automatic logic [7:0] sat_angle(input logic [7:0] a);
    if (a < ANGLE_MIN)      return ANGLE_MIN;
    else if (a > ANGLE_MAX) return ANGLE_MAX;
    else                    return a;
  endfunction

  function automatic logic [47:0] clamp_pose(input logic [47:0] p);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 6; j++) r[j*8 +: 8] = sat_angle(p[j*8 +: 8]);
    return r;
  endfunction

  // The counter shows how many full cycles have been spent in the current
  // state, so "cnt + 1 reaches the limit" marks the last cycle of a phase.
  assign cnt_inc   = {1'b0, cnt_r} + 33'd1;
  assign guard_end = (cnt_inc >= GUARD_LIM);
  assign wait_tmo  = (cnt_inc >= TMO_LIM);
  assign dwell_end = (cnt_inc >= DWELL_LIM);
  assign settled   = (iDone == 6'b111111);
  assign last_r    = last_step(mode_e'(mode_r));
  assign at_last   = (step_r == last_r);

  always_ff @(posedge iClk) begin
    if (iRst) state_r <= ST_IDLE;
    else      state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    unique case (state_r)
      ST_IDLE:  if (iEnable) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_GUARD;
      ST_GUARD: if (guard_end) state_nxt = ST_WAIT;
      // Settling is checked first so it wins over a same-cycle timeout.
      ST_WAIT: begin
        if (settled)       state_nxt = ST_DWELL;
        else if (wait_tmo) state_nxt = ST_FAULT;
      end
      ST_DWELL: begin
        if (dwell_end) begin
          if (!at_last || iEnable) state_nxt = ST_LOAD;
          else                     state_nxt = ST_IDLE;
        end
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    oBusy      = (state_r != ST_IDLE);
    oFault     = (state_r == ST_FAULT);
    oCycleDone = (state_r == ST_DWELL) && dwell_end && at_last;
    oAngles    = angles_p1;
    oStep      = step_r;
  end

  // Mode is only sampled at a cycle boundary, so mid-cycle iMode changes
  // and a falling iEnable never disturb the poses already in progress.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_r  <= '0;
      mode_r <= 2'd0;
      step_r <= 3'd0;
    end else begin
      if ((state_nxt == state_r) &&
          (state_r == ST_GUARD || state_r == ST_WAIT || state_r == ST_DWELL))
        cnt_r <= cnt_r + 32'd1;
      else
        cnt_r <= '0;

      if (state_r == ST_IDLE && iEnable) begin
        mode_r <= iMode;
        step_r <= 3'd0;
      end else if (state_r == ST_DWELL && dwell_end) begin
        if (!at_last) begin
          step_r <= step_r + 3'd1;
        end else if (iEnable) begin
          mode_r <= iMode;
          step_r <= 3'd0;
        end
      end
    end
  end

  // Stage p0: table lookup for (mode_r, step_r)
  gait_pose_rom u_rom (
    .mode (mode_r),
    .step (step_r),
    .pose (pose_p0)
  );

  // Stage p1: clamped pose registered during LOAD; neutral whenever idle
  always_ff @(posedge iClk) begin
    if (iRst)                      angles_p1 <= NEUTRAL_POSE;
    else if (state_r == ST_LOAD)   angles_p1 <= clamp_pose(pose_p0);
    else if (state_nxt == ST_IDLE) angles_p1 <= NEUTRAL_POSE;
  end

endmodule

// File: tb/tb_gait_sequencer.sv
// tb_gait_sequencer -- directed bench for gait_sequencer with short
// timing parameters (DWELL 4, GUARD 2, TIMEOUT 20). A second instance
// with a narrow clamp window (65..105) shares all inputs.
module tb_gait_sequencer;

  localparam int DW = 4;
  localparam int GD = 2;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [5:0]  done;
  logic [47:0] ang, ang_c;
  logic [2:0]  step, step_c;
  logic        busy, cd, flt;
  logic        busy_c, cd_c, flt_c;

  int n_vec  = 0;
  int n_miss = 0;

  logic [47:0] neu;
  logic [47:0] fwd [6];
  logic [47:0] rgt [3];
  logic [47:0] lft [3];

  always #10 clk = ~clk;

  gait_sequencer #(
    .DWELL_CYC(DW), .TIMEOUT_CYC(TO), .GUARD_CYC(GD),
    .ANGLE_MIN(8'd30), .ANGLE_MAX(8'd150)
  ) dut (
    .iClk(clk), .iRst(rst), .iEnable(en), .iMode(mode), .iDone(done),
    .oAngles(ang), .oStep(step), .oBusy(busy), .oCycleDone(cd), .oFault(flt)
  );

  gait_sequencer #(
    .DWELL_CYC(DW), .TIMEOUT_CYC(TO), .GUARD_CYC(GD),
    .ANGLE_MIN(8'd65), .ANGLE_MAX(8'd105)
  ) u_clamp (
    .iClk(clk), .iRst(rst), .iEnable(en), .iMode(mode), .iDone(done),
    .oAngles(ang_c), .oStep(step_c), .oBusy(busy_c), .oCycleDone(cd_c), .oFault(flt_c)
  );

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] pose6(input int l1, input int l2, input int l3,
                                        input int r1, input int r2, input int r3);
    return {r3[7:0], r2[7:0], r1[7:0], l3[7:0], l2[7:0], l1[7:0]};
  endfunction

  function automatic logic [47:0] clampx(input logic [47:0] p);
    logic [47:0] r;
    logic [7:0]  a;
    r = '0;
    for (int j = 0; j < 6; j++) begin
      a = p[j*8 +: 8];
      r[j*8 +: 8] = (a < 8'd65) ? 8'd65 : ((a > 8'd105) ? 8'd105 : a);
    end
    return r;
  endfunction

  // Called right after the edge that puts the sequencer in LOAD for step k.
  // Returns right after the edge that leaves the final DWELL cycle.
  task automatic step_phase(input int k, input logic [47:0] pose, input logic last);
    chk($sformatf("step%0d_idx", k), {45'd0, step}, 48'(k));
    tick(1);
    chk($sformatf("step%0d_ang", k), ang, pose);
    chk($sformatf("step%0d_clamp", k), ang_c, clampx(pose));
    tick(5);
    chk($sformatf("step%0d_cd_early", k), {47'd0, cd}, 48'd0);
    tick(1);
    chk($sformatf("step%0d_cd_end", k), {47'd0, cd}, {47'd0, last});
    tick(1);
  endtask

  initial begin
    neu    = pose6(90, 90, 90, 90, 90, 90);
    fwd[0] = pose6(60, 90, 90, 60, 90, 90);
    fwd[1] = pose6(70, 110, 110, 70, 90, 110);
    fwd[2] = pose6(90, 110, 110, 90, 90, 110);
    fwd[3] = pose6(110, 90, 70, 110, 70, 70);
    fwd[4] = pose6(90, 90, 70, 90, 70, 70);
    fwd[5] = neu;
    rgt[0] = pose6(90, 60, 60, 100, 60, 60);
    rgt[1] = pose6(80, 120, 120, 80, 120, 120);
    rgt[2] = neu;
    lft[0] = pose6(80, 120, 120, 90, 120, 120);
    lft[1] = pose6(100, 60, 60, 100, 60, 60);
    lft[2] = neu;

    rst = 1'b1; en = 1'b0; mode = 2'd0; done = 6'h00;
    tick(2);
    chk("rst_ang",  ang, neu);
    chk("rst_step", {45'd0, step}, 48'd0);
    chk("rst_busy", {47'd0, busy}, 48'd0);
    chk("rst_cd",   {47'd0, cd}, 48'd0);
    chk("rst_flt",  {47'd0, flt}, 48'd0);
    rst = 1'b0;
    tick(1);
    chk("idle_busy", {47'd0, busy}, 48'd0);

    // One full forward cycle with every joint reporting settled.
    mode = 2'd1; en = 1'b1; done = 6'h3F;
    tick(1);
    chk("run_busy", {47'd0, busy}, 48'd1);
    for (int k = 0; k < 6; k++) step_phase(k, fwd[k], k == 5);

    // Second forward cycle; mode switch to right mid-cycle takes effect
    // only at the wrap.
    for (int k = 0; k < 3; k++) step_phase(k, fwd[k], 1'b0);
    mode = 2'd2;
    for (int k = 3; k < 6; k++) step_phase(k, fwd[k], k == 5);
    mode = 2'd3;
    for (int k = 0; k < 3; k++) step_phase(k, rgt[k], k == 2);

    // Left cycle with enable dropped at step 1: cycle still completes.
    step_phase(0, lft[0], 1'b0);
    en = 1'b0;
    step_phase(1, lft[1], 1'b0);
    step_phase(2, lft[2], 1'b1);
    chk("stop_busy", {47'd0, busy}, 48'd0);
    chk("stop_ang",  ang, neu);
    chk("stop_cd",   {47'd0, cd}, 48'd0);
    tick(3);
    chk("stop_busy_hold", {47'd0, busy}, 48'd0);

    // Settle reported only during GUARD, then one joint never settles.
    done = 6'h00; mode = 2'd1; en = 1'b1;
    tick(2);
    done = 6'h3F;
    tick(2);
    done = 6'h1F; en = 1'b0;
    tick(TO - 1);
    chk("tmo_not_yet", {47'd0, flt}, 48'd0);
    chk("tmo_busy",    {47'd0, busy}, 48'd1);
    tick(1);
    chk("tmo_flt",   {47'd0, flt}, 48'd1);
    chk("tmo_ang",   ang, fwd[0]);
    chk("tmo_step",  {45'd0, step}, 48'd0);
    tick(3);
    chk("flt_sticky", {47'd0, flt}, 48'd1);
    chk("flt_frozen", ang, fwd[0]);
    rst = 1'b1;
    tick(1);
    chk("frst_ang",  ang, neu);
    chk("frst_step", {45'd0, step}, 48'd0);
    chk("frst_busy", {47'd0, busy}, 48'd0);
    chk("frst_cd",   {47'd0, cd}, 48'd0);
    chk("frst_flt",  {47'd0, flt}, 48'd0);
    rst = 1'b0;
    tick(1);

    // Stand pose: settle arrives on the very cycle the timeout would hit.
    done = 6'h00; mode = 2'd0; en = 1'b1;
    tick(4);
    en = 1'b0;
    tick(TO - 1);
    done = 6'h3F;
    tick(1);
    chk("tie_flt",  {47'd0, flt}, 48'd0);
    chk("tie_busy", {47'd0, busy}, 48'd1);
    tick(DW - 1);
    chk("stand_cd", {47'd0, cd}, 48'd1);
    // Reset on the pulse cycle must leave no pulse behind.
    rst = 1'b1;
    tick(1);
    chk("drst_cd",   {47'd0, cd}, 48'd0);
    chk("drst_busy", {47'd0, busy}, 48'd0);
    rst = 1'b0;
    tick(1);
    chk("drst_cd2",  {47'd0, cd}, 48'd0);
    chk("drst_idle", {47'd0, busy}, 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
